// File: rtl/neo_fix_fetch.sv
// neo_fix_fetch: per-line fix map walker; reads one tile word per column over a req/ack
// VRAM port and replays each word as a strobed address/data pair on the fix snoop bus.
module neo_fix_fetch #(
    parameter int          COLS     = 42,
    parameter logic [10:0] PRE_ADDR = 11'h7E2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pck2_i,
    input  logic        line_start_i,
    input  logic [4:0]  row_i,
    input  logic        fix_en_i,
    output logic        vram_rd_o,
    output logic [10:0] vram_addr_o,
    input  logic [15:0] vram_data_i,
    input  logic        vram_ack_i,
    output logic [10:0] addr_o,
    output logic [14:0] pbus_o,
    output logic        strobe_o,
    output logic        busy_o,
    output logic        late_o
);
    typedef enum logic [2:0] {IDLE, PRE0, PRE1, REQ, HOLD0, HOLD1} state_t;

    state_t      state_q;
    logic [5:0]  col_q;
    logic [5:0]  col_d;
    logic [4:0]  row_q;
    logic [10:0] vram_addr_q;
    logic [10:0] addr_q;
    logic [14:0] pbus_q;
    logic        late_q;
    logic        last_col;
    logic        unused_data;

    assign col_d       = col_q + 6'd1;
    assign last_col    = col_q == 6'(COLS - 1);
    assign unused_data = vram_data_i[15];

    assign vram_rd_o   = state_q == REQ;
    assign vram_addr_o = vram_addr_q;
    assign addr_o      = addr_q;
    assign pbus_o      = pbus_q;
    assign busy_o      = state_q != IDLE;
    assign late_o      = late_q;
    // The snoop edge coincides with the PCK2 slot that advances the state.
    assign strobe_o    = pck2_i && (state_q inside {PRE0, PRE1, HOLD0, HOLD1});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            vram_addr_q <= '0;
            addr_q      <= '0;
            pbus_q      <= '0;
            late_q      <= 1'b0;
        end else begin
            late_q <= line_start_i && busy_o;
            if (line_start_i) begin
                if (fix_en_i) begin
                    state_q <= PRE0;
                    row_q   <= row_i;
                    col_q   <= '0;
                    addr_q  <= PRE_ADDR;
                    pbus_q  <= '0;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    PRE0: if (pck2_i) state_q <= PRE1;
                    PRE1: if (pck2_i) begin
                        state_q     <= REQ;
                        vram_addr_q <= {col_q, row_q};
                    end
                    REQ: if (vram_ack_i) begin
                        state_q <= HOLD0;
                        addr_q  <= vram_addr_q;
                        pbus_q  <= vram_data_i[14:0];
                    end
                    HOLD0: if (pck2_i) state_q <= HOLD1;
                    HOLD1: if (pck2_i) begin
                        if (last_col) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= REQ;
                            col_q       <= col_d;
                            vram_addr_q <= {col_d, row_q};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
